ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, SHALL set the data-RAM word address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the data width.
REQ-003 Parameter STARVE_LIMIT, default 4, SHALL set the consecutive DMA wait cycles before forced grant.
REQ-004 i_clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 i_rst  in  1  SHALL be the synchronous, active-high reset.
REQ-006 i_core_req / i_core_we  in  1 each  SHALL be the core MEM-stage access request and write enable.
REQ-007 i_core_addr  in  ADDR_WIDTH; i_core_wdata  in  DATA_WIDTH  SHALL be the core address and store data.
REQ-008 o_core_rdata  out  DATA_WIDTH; o_core_stall  out  1  SHALL be the core load data and the pipeline-freeze request.
REQ-009 i_dma_valid  in  1; o_dma_ready  out  1  SHALL form the DMA/loader request handshake.
REQ-010 i_dma_we  in  1; i_dma_addr  in  ADDR_WIDTH; i_dma_wdata  in  DATA_WIDTH  SHALL be the DMA request payload.
REQ-011 o_dma_rvalid  out  1; o_dma_rdata  out  DATA_WIDTH  SHALL return DMA read data.
REQ-012 o_ram_addr, o_ram_wdata, o_ram_we  out; i_ram_rdata  in  SHALL connect to the combinational-read, synchronous-write data RAM.
REQ-013 i_halt_req  in  1; o_halt_ack  out  1  SHALL be the debug halt request and acknowledge.

Function
REQ-014 FSM states SHALL be RUN and HALTED; RUN->HALTED at an edge with i_halt_req=1; HALTED->RUN at an edge with i_halt_req=0.
REQ-015 o_halt_ack SHALL be 1 exactly when state is HALTED.
REQ-016 In HALTED, DMA SHALL be granted every cycle and o_core_stall SHALL be 1 regardless of i_core_req.
REQ-017 In RUN, the core SHALL win when i_core_req=1, except a forced DMA grant (REQ-020).
REQ-018 In RUN with i_core_req=0, DMA SHALL be granted; o_core_stall SHALL be 1 only when i_core_req=1 and DMA is granted.
REQ-019 o_dma_ready SHALL equal the combinational DMA grant; a transfer occurs when i_dma_valid and o_dma_ready are both 1.
REQ-020 Wait counter SHALL increment (saturating at STARVE_LIMIT) each cycle i_dma_valid=1 and o_dma_ready=0; clear on transfer or i_dma_valid=0; counter==STARVE_LIMIT SHALL force a DMA grant over the core.
REQ-021 RAM port SHALL carry the granted requester's addr/wdata; o_ram_we SHALL be i_core_req&i_core_we (core grant) or i_dma_valid&i_dma_we (DMA grant), else 0; ungranted-idle default addr SHALL be i_core_addr.
REQ-022 o_core_rdata SHALL be i_ram_rdata combinationally (zero-latency load).
REQ-023 Accepted DMA read SHALL assert o_dma_rvalid for exactly one cycle on the next cycle, with o_dma_rdata registered from i_ram_rdata; back-to-back reads SHALL give back-to-back rvalid.
REQ-024 o_dma_rdata SHALL hold its last value when o_dma_rvalid=0.
REQ-025 Halt change coincident with a request SHALL not affect that cycle; arbitration uses current state.

Reset
REQ-026 i_rst SHALL set state RUN, counter 0, o_dma_rvalid 0, o_dma_rdata 0, o_halt_ack 0.
REQ-027 Reset mid-operation SHALL discard any pending read return; during reset o_ram_we SHALL be 0 and o_dma_ready 0.

Configuration
REQ-028 Macro RAM_ARB_STARVE_EN defined SHALL include the wait counter and forced grant (REQ-020).
REQ-029 Without RAM_ARB_STARVE_EN, no counter SHALL exist and the core SHALL always win in RUN; all other behaviour identical.

Structure
REQ-030 Shared package SHALL hold the FSM state encoding (RUN, HALTED) and grant-select constants (GNT_CORE, GNT_DMA).
REQ-031 One sub-module, ram_arb_wait_cnt (saturating counter with clear), SHALL implement REQ-020.

Verification
REQ-032 Core idle, DMA write addr 3 data 0xA5A5A5A5 -> ready=1 same cycle, o_ram_we=1, addr 3; core load addr 3 later returns 0xA5A5A5A5.
REQ-033 Core req every cycle, DMA valid, STARVE_LIMIT=4 -> DMA granted on 5th cycle, o_core_stall=1 that cycle only; without macro DMA never granted.
REQ-034 DMA reads addr 1,2 back-to-back (RAM 0x11,0x22) -> rvalid high two consecutive cycles, rdata 0x11 then 0x22.
REQ-035 i_halt_req=1 with core req -> next cycle o_halt_ack=1, o_core_stall=1, DMA ready=1; deassert -> RUN next cycle, stall drops.
REQ-036 i_rst=1 cycle after accepted DMA read -> o_dma_rvalid=0, counter 0, state RUN.
REQ-037 Simultaneous core store addr 7 and DMA store addr 7 (no starvation) -> only core data written, DMA ready=0.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the data-RAM arbiter: FSM states and grant-select values.
package ram_arbiter_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } arb_state_e;

  typedef enum logic {
    GNT_CORE = 1'b0,
    GNT_DMA  = 1'b1
  } gnt_sel_e;

endpackage

// File: rtl/ram_arb_wait_cnt.sv
// Saturating DMA wait counter with clear; o_sat forces a DMA grant once the limit is hit.
module ram_arb_wait_cnt #(
  parameter int LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_sat = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/ram_arbiter.sv
// Data-RAM arbiter between the core MEM stage and a DMA/loader port, with debug halt.
// Define RAM_ARB_STARVE_EN to add the DMA starvation counter and forced DMA grant.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_core_req,
  input  logic                  i_core_we,
  input  logic [ADDR_WIDTH-1:0] i_core_addr,
  input  logic [DATA_WIDTH-1:0] i_core_wdata,
  output logic [DATA_WIDTH-1:0] o_core_rdata,
  output logic                  o_core_stall,
  input  logic                  i_dma_valid,
  output logic                  o_dma_ready,
  input  logic                  i_dma_we,
  input  logic [ADDR_WIDTH-1:0] i_dma_addr,
  input  logic [DATA_WIDTH-1:0] i_dma_wdata,
  output logic                  o_dma_rvalid,
  output logic [DATA_WIDTH-1:0] o_dma_rdata,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata,
  input  logic                  i_halt_req,
  output logic                  o_halt_ack
);

  // state  | meaning
  // RUN    | core has priority, DMA uses cycles the core leaves idle
  // HALTED | debug halt: core frozen, DMA owns the RAM every cycle

  arb_state_e            state_q, state_d;
  gnt_sel_e              gnt;
  logic                  force_dma;
  logic                  dma_ready;
  logic                  dma_rd_acc;
  logic                  dma_rvalid_q, dma_rvalid_d;
  logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;

`ifdef RAM_ARB_STARVE_EN
  ram_arb_wait_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_wait_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (i_dma_valid && !dma_ready),
    .i_clr (!i_dma_valid || dma_ready),
    .o_sat (force_dma)
  );
`else
  logic starve_limit_unused;
  assign starve_limit_unused = (STARVE_LIMIT != 0);
  assign force_dma           = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (i_halt_req)  state_d = HALTED;
      HALTED:  if (!i_halt_req) state_d = RUN;
      default: state_d = RUN;
    endcase

    gnt = GNT_CORE;
    if ((state_q == HALTED) || !i_core_req || force_dma) gnt = GNT_DMA;

    dma_ready    = (gnt == GNT_DMA) && !i_rst;
    o_core_stall = (state_q == HALTED) || (i_core_req && (gnt == GNT_DMA));

    // Idle default keeps the core address on the bus so loads stay zero-latency.
    o_ram_addr  = i_core_addr;
    o_ram_wdata = i_core_wdata;
    o_ram_we    = 1'b0;
    if (gnt == GNT_CORE) begin
      o_ram_we = i_core_req && i_core_we;
    end else if (i_dma_valid) begin
      o_ram_addr  = i_dma_addr;
      o_ram_wdata = i_dma_wdata;
      o_ram_we    = i_dma_we;
    end
    if (i_rst) o_ram_we = 1'b0;

    dma_rd_acc   = i_dma_valid && dma_ready && !i_dma_we;
    dma_rvalid_d = dma_rd_acc;
    dma_rdata_d  = dma_rd_acc ? i_ram_rdata : dma_rdata_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= RUN;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign o_dma_ready  = dma_ready;
  assign o_halt_ack   = (state_q == HALTED);
  assign o_core_rdata = i_ram_rdata;
  assign o_dma_rvalid = dma_rvalid_q;
  assign o_dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: RAM model, direct checks and a DMA read-return scoreboard.
module tb_ram_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SL = 4;
`ifdef RAM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req, core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          core_stall;
  logic          dma_valid, dma_ready, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          ram_we;
  logic          halt_req, halt_ack;

  logic [DW-1:0] mem [0:31];

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_core_req   (core_req),
    .i_core_we    (core_we),
    .i_core_addr  (core_addr),
    .i_core_wdata (core_wdata),
    .o_core_rdata (core_rdata),
    .o_core_stall (core_stall),
    .i_dma_valid  (dma_valid),
    .o_dma_ready  (dma_ready),
    .i_dma_we     (dma_we),
    .i_dma_addr   (dma_addr),
    .i_dma_wdata  (dma_wdata),
    .o_dma_rvalid (dma_rvalid),
    .o_dma_rdata  (dma_rdata),
    .o_ram_addr   (ram_addr),
    .o_ram_wdata  (ram_wdata),
    .o_ram_we     (ram_we),
    .i_ram_rdata  (ram_rdata),
    .i_halt_req   (halt_req),
    .o_halt_ack   (halt_ack)
  );

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    dma_valid = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    halt_req = 0;
  endtask

  task automatic push_exp(input logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + 1;
    sb_q.push_back(e);
  endtask

  // Read-return monitor: every rvalid must match the oldest expected read, one cycle after issue.
  always @(negedge clk) begin
    if (dma_rvalid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rvalid_unexpected: got rvalid=1 rdata=%0h expected no return", dma_rdata);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("dma_rdata", dma_rdata, e.data);
        chk("rvalid_cycle", DW'(cyc), DW'(e.cyc));
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] <= '0;
    mem[1] <= 32'h11;
    mem[2] <= 32'h22;
    set_idle();
    rst = 1;

    // Reset: DMA request must be refused and no write may reach the RAM.
    @(negedge clk);
    @(negedge clk);
    dma_valid = 1; dma_we = 1; dma_addr = 5'd4; dma_wdata = 32'hBAD0BAD0;
    #1;
    chk("rst_dma_ready", DW'(dma_ready), 0);
    chk("rst_ram_we", DW'(ram_we), 0);
    @(negedge clk);
    rst = 0; set_idle();
    #1;
    chk("rst_rvalid", DW'(dma_rvalid), 0);
    chk("rst_rdata", dma_rdata, 0);
    chk("rst_halt_ack", DW'(halt_ack), 0);

    // DMA write with core idle, then core load of the same word.
    @(negedge clk);
    dma_valid = 1; dma_we = 1; dma_addr = 5'd3; dma_wdata = 32'hA5A5A5A5;
    #1;
    chk("dmaw_ready", DW'(dma_ready), 1);
    chk("dmaw_ram_we", DW'(ram_we), 1);
    chk("dmaw_ram_addr", DW'(ram_addr), 3);
    chk("dmaw_stall", DW'(core_stall), 0);
    @(negedge clk);
    set_idle(); core_req = 1; core_addr = 5'd3;
    #1;
    chk("load3_rdata", core_rdata, 32'hA5A5A5A5);
    chk("load3_ram_we", DW'(ram_we), 0);
    chk("load3_dma_ready", DW'(dma_ready), 0);

    // Simultaneous stores to addr 7: core wins.
    @(negedge clk);
    core_req = 1; core_we = 1; core_addr = 5'd7; core_wdata = 32'h77777777;
    dma_valid = 1; dma_we = 1; dma_addr = 5'd7; dma_wdata = 32'hDEADBEEF;
    #1;
    chk("coll_dma_ready", DW'(dma_ready), 0);
    chk("coll_ram_we", DW'(ram_we), 1);
    chk("coll_ram_wdata", ram_wdata, 32'h77777777);
    chk("coll_stall", DW'(core_stall), 0);
    @(negedge clk);
    set_idle(); core_req = 1; core_addr = 5'd7;
    #1;
    chk("load7_rdata", core_rdata, 32'h77777777);

    // Back-to-back DMA reads of addr 1 and 2.
    @(negedge clk);
    set_idle(); dma_valid = 1; dma_addr = 5'd1;
    #1;
    chk("rd1_ready", DW'(dma_ready), 1);
    chk("rd1_ram_addr", DW'(ram_addr), 1);
    push_exp(32'h11);
    @(negedge clk);
    dma_addr = 5'd2;
    #1;
    chk("rd2_ready", DW'(dma_ready), 1);
    push_exp(32'h22);
    @(negedge clk);
    set_idle();
    @(negedge clk);
    #1;
    chk("rdata_hold_rvalid", DW'(dma_rvalid), 0);
    chk("rdata_hold", dma_rdata, 32'h22);

    // Core busy every cycle: DMA only gets in when starvation forcing is built in.
    for (int i = 1; i <= 10; i++) begin
      logic g;
      @(negedge clk);
      core_req = 1; core_we = 0; core_addr = 5'd0;
      dma_valid = 1; dma_we = 1; dma_addr = 5'd9; dma_wdata = 32'h99;
      #1;
      g = STARVE && (i == 5 || i == 10);
      chk($sformatf("starve_ready_%0d", i), DW'(dma_ready), DW'(g));
      chk($sformatf("starve_stall_%0d", i), DW'(core_stall), DW'(g));
      chk($sformatf("starve_addr_%0d", i), DW'(ram_addr), g ? 32'd9 : 32'd0);
      chk($sformatf("starve_we_%0d", i), DW'(ram_we), DW'(g));
    end
    @(negedge clk);
    set_idle(); core_req = 1; core_addr = 5'd9;
    #1;
    chk("load9_rdata", core_rdata, STARVE ? 32'h99 : 32'h0);

    // Reset part-way through a wait run restarts the count from zero.
    for (int i = 1; i <= 8; i++) begin
      logic g;
      @(negedge clk);
      rst = (i == 3);
      core_req = 1; core_we = 0; core_addr = 5'd0;
      dma_valid = 1; dma_we = 1; dma_addr = 5'd10; dma_wdata = 32'h10;
      #1;
      g = STARVE && (i == 8);
      chk($sformatf("rstcnt_ready_%0d", i), DW'(dma_ready), DW'(g));
      chk($sformatf("rstcnt_we_%0d", i), DW'(ram_we), DW'(g));
    end
    @(negedge clk);
    set_idle();

    // Halt request coincident with a core access, then release.
    @(negedge clk);
    core_req = 1; core_addr = 5'd3; halt_req = 1;
    dma_valid = 1; dma_we = 0; dma_addr = 5'd2;
    #1;
    chk("halt0_ack", DW'(halt_ack), 0);
    chk("halt0_ready", DW'(dma_ready), 0);
    chk("halt0_stall", DW'(core_stall), 0);
    @(negedge clk);
    #1;
    chk("halt1_ack", DW'(halt_ack), 1);
    chk("halt1_stall", DW'(core_stall), 1);
    chk("halt1_ready", DW'(dma_ready), 1);
    chk("halt1_ram_addr", DW'(ram_addr), 2);
    push_exp(32'h22);
    @(negedge clk);
    halt_req = 0; dma_valid = 0;
    #1;
    chk("halt2_ack", DW'(halt_ack), 1);
    chk("halt2_stall", DW'(core_stall), 1);
    @(negedge clk);
    #1;
    chk("run_ack", DW'(halt_ack), 0);
    chk("run_stall", DW'(core_stall), 0);
    chk("run_core_rdata", core_rdata, 32'hA5A5A5A5);

    // Reset right after an accepted DMA read taken while halted.
    @(negedge clk);
    set_idle(); halt_req = 1;
    @(negedge clk);
    dma_valid = 1; dma_we = 0; dma_addr = 5'd1;
    #1;
    chk("hrd_ready", DW'(dma_ready), 1);
    push_exp(32'h11);
    @(negedge clk);
    set_idle(); rst = 1;
    #1;
    chk("hrst_dma_ready", DW'(dma_ready), 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("post_rst_rvalid", DW'(dma_rvalid), 0);
    chk("post_rst_rdata", dma_rdata, 0);
    chk("post_rst_ack", DW'(halt_ack), 0);
    chk("post_rst_stall", DW'(core_stall), 0);

    repeat (3) @(negedge clk);
    #1;
    chk("sb_empty", DW'(sb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
